// File: rtl/dcache_wr_pkg.sv
// Shared types for the data-array write sink: the queued write entry and the sink FSM states.
// Field widths live here because the entry struct is shared by the queue and the top.
package dcache_wr_pkg;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 64;
  localparam int NWAYS   = 1;
  localparam int WMASK_W = 1;

  typedef struct packed {
    logic [NWAYS-1:0]   way_en;
    logic [ADDR_W-1:0]  addr;
    logic [WMASK_W-1:0] wmask;
    logic [DATA_W-1:0]  data;
    logic               src;
  } wr_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FORCE = 2'd2
  } sink_state_e;

endpackage

// File: rtl/dcache_wr_queue.sv
// Circular FIFO of pending data-array writes with a youngest-match lookup port used to
// forward still-pending write data to a colliding read.
module dcache_wr_queue
  import dcache_wr_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  wr_entry_t          push_entry,
  input  logic               pop,
  output wr_entry_t          head,
  output logic [CNT_W-1:0]   count,
  input  logic [NWAYS-1:0]   query_way_en,
  input  logic [ADDR_W-1:0]  query_addr,
  output logic               fwd_hit,
  output logic [WMASK_W-1:0] fwd_wmask,
  output logic [DATA_W-1:0]  fwd_data
);

  wr_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Slot holding the k-th oldest entry, wrapping modulo DEPTH.
  function automatic logic [PTR_W-1:0] slot_of(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is tracked solely by count and
  // pointers, so stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

  // Scan oldest to youngest so the last match (the youngest) wins; the head still
  // counts while it is being popped because count only drops after the edge.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_wmask = '0;
    fwd_data  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(count)) begin
        if (mem[slot_of(rd_ptr, k)].addr == query_addr &&
            mem[slot_of(rd_ptr, k)].way_en == query_way_en) begin
          fwd_hit   = 1'b1;
          fwd_wmask = mem[slot_of(rd_ptr, k)].wmask;
          fwd_data  = mem[slot_of(rd_ptr, k)].data;
        end
      end
    end
  end

endmodule

// File: rtl/dcache_data_write_sink.sv
// Receiving end of the data-array write arbiter: queues arbitrated writes, drains them when
// no read owns the array, forces a write after a run of blocked cycles, and acks commits.
module dcache_data_write_sink
  import dcache_wr_pkg::*;
#(
  parameter  int DEPTH        = 2,
  parameter  int STARVE_LIMIT = 4,
  localparam int CNT_W        = $clog2(DEPTH + 1),
  localparam int ST_W         = $clog2(STARVE_LIMIT + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_req_valid,
  output logic               io_req_ready,
  input  logic [NWAYS-1:0]   io_req_way_en,
  input  logic [ADDR_W-1:0]  io_req_addr,
  input  logic [WMASK_W-1:0] io_req_wmask,
  input  logic [DATA_W-1:0]  io_req_data,
  input  logic               io_req_chosen,
  input  logic               io_rd_valid,
  input  logic [NWAYS-1:0]   io_rd_way_en,
  input  logic [ADDR_W-1:0]  io_rd_addr,
  output logic               io_rd_stall,
  output logic               io_fwd_hit,
  output logic [WMASK_W-1:0] io_fwd_wmask,
  output logic [DATA_W-1:0]  io_fwd_data,
  output logic               io_sram_wen,
  output logic [NWAYS-1:0]   io_sram_way_en,
  output logic [ADDR_W-1:0]  io_sram_addr,
  output logic [WMASK_W-1:0] io_sram_wmask,
  output logic [DATA_W-1:0]  io_sram_wdata,
  output logic               io_ack_valid,
  output logic               io_ack_source,
  output logic               io_empty
);

  sink_state_e      state, state_next;
  logic [ST_W-1:0]  starve, starve_next;
  logic [CNT_W-1:0] count;
  wr_entry_t        req_entry, head;
  logic             empty, full, push, pop, last_pop;

  assign req_entry = '{way_en: io_req_way_en, addr: io_req_addr, wmask: io_req_wmask,
                       data: io_req_data, src: io_req_chosen};

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign push     = io_req_valid & ~full;
  assign pop      = io_sram_wen;
  assign last_pop = pop & ~push & (count == CNT_W'(1));

  dcache_wr_queue #(.DEPTH(DEPTH)) u_queue (
    .clock        (clock),
    .reset        (reset),
    .push         (push),
    .push_entry   (req_entry),
    .pop          (pop),
    .head         (head),
    .count        (count),
    .query_way_en (io_rd_way_en),
    .query_addr   (io_rd_addr),
    .fwd_hit      (io_fwd_hit),
    .fwd_wmask    (io_fwd_wmask),
    .fwd_data     (io_fwd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      starve        <= '0;
      io_ack_valid  <= 1'b0;
      io_ack_source <= 1'b0;
    end else begin
      state        <= state_next;
      starve       <= starve_next;
      io_ack_valid <= pop;
      if (pop) io_ack_source <= head.src;
    end
  end

  always_comb begin
    state_next  = state;
    starve_next = starve;
    case (state)
      IDLE: begin
        if (push) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop) begin
          starve_next = '0;
          if (last_pop) state_next = IDLE;
        end else if (io_rd_valid) begin
          if (starve != ST_W'(STARVE_LIMIT)) starve_next = starve + 1'b1;
          if (starve_next == ST_W'(STARVE_LIMIT)) state_next = FORCE;
        end
      end
      FORCE: begin
        starve_next = '0;
        state_next  = last_pop ? IDLE : DRAIN;
      end
      default: begin
        state_next  = IDLE;
        starve_next = '0;
      end
    endcase
  end

  // A forced cycle owns the array: the read backs off and the head is written.
  always_comb begin
    io_rd_stall = (state == FORCE);
    io_sram_wen = ~empty & (~io_rd_valid | (state == FORCE));
  end

  assign io_req_ready   = ~full;
  assign io_empty       = empty;
  assign io_sram_way_en = head.way_en;
  assign io_sram_addr   = head.addr;
  assign io_sram_wmask  = head.wmask;
  assign io_sram_wdata  = head.data;

endmodule

// File: tb/tb_dcache_data_write_sink.sv
// Directed and randomized bench for dcache_data_write_sink against a queue-based reference
// model of the pending-write list, starvation rule and registered acks.
module tb_dcache_data_write_sink;
  import dcache_wr_pkg::*;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               io_req_valid, io_req_ready, io_req_chosen;
  logic [NWAYS-1:0]   io_req_way_en, io_rd_way_en, io_sram_way_en;
  logic [ADDR_W-1:0]  io_req_addr, io_rd_addr, io_sram_addr;
  logic [WMASK_W-1:0] io_req_wmask, io_fwd_wmask, io_sram_wmask;
  logic [DATA_W-1:0]  io_req_data, io_fwd_data, io_sram_wdata;
  logic               io_rd_valid, io_rd_stall, io_fwd_hit, io_sram_wen;
  logic               io_ack_valid, io_ack_source, io_empty;

  int tests = 0;
  int fails = 0;

  // Reference model: list of pending writes oldest first, blocked-cycle tally, pending force.
  wr_entry_t pend[$];
  int        starve_m = 0;
  bit        force_m  = 1'b0;
  bit        ack_v_m  = 1'b0;
  bit        ack_s_m  = 1'b0;

  dcache_data_write_sink #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_req_valid   (io_req_valid),
    .io_req_ready   (io_req_ready),
    .io_req_way_en  (io_req_way_en),
    .io_req_addr    (io_req_addr),
    .io_req_wmask   (io_req_wmask),
    .io_req_data    (io_req_data),
    .io_req_chosen  (io_req_chosen),
    .io_rd_valid    (io_rd_valid),
    .io_rd_way_en   (io_rd_way_en),
    .io_rd_addr     (io_rd_addr),
    .io_rd_stall    (io_rd_stall),
    .io_fwd_hit     (io_fwd_hit),
    .io_fwd_wmask   (io_fwd_wmask),
    .io_fwd_data    (io_fwd_data),
    .io_sram_wen    (io_sram_wen),
    .io_sram_way_en (io_sram_way_en),
    .io_sram_addr   (io_sram_addr),
    .io_sram_wmask  (io_sram_wmask),
    .io_sram_wdata  (io_sram_wdata),
    .io_ack_valid   (io_ack_valid),
    .io_ack_source  (io_ack_source),
    .io_empty       (io_empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic set_req(input bit v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input bit src);
    io_req_valid  = v;
    io_req_addr   = a;
    io_req_data   = d;
    io_req_chosen = src;
    io_req_way_en = 1'b1;
    io_req_wmask  = 1'b1;
  endtask

  task automatic set_rd(input bit v, input logic [ADDR_W-1:0] a);
    io_rd_valid  = v;
    io_rd_addr   = a;
    io_rd_way_en = 1'b1;
  endtask

  // One clock: compare all outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    bit                 wen_e, hit_e, push_e, was_busy;
    logic [DATA_W-1:0]  fd_e;
    logic [WMASK_W-1:0] fm_e;
    wr_entry_t          e;
    @(negedge clock);
    wen_e = (pend.size() > 0) && (!io_rd_valid || force_m);
    check("req_ready", io_req_ready, pend.size() != DEPTH);
    check("sram_wen", io_sram_wen, wen_e);
    check("rd_stall", io_rd_stall, force_m);
    check("empty", io_empty, pend.size() == 0);
    check("ack_valid", io_ack_valid, ack_v_m);
    if (ack_v_m) check("ack_source", io_ack_source, ack_s_m);
    if (wen_e) begin
      check("sram_addr", io_sram_addr, pend[0].addr);
      check("sram_wdata", io_sram_wdata, pend[0].data);
      check("sram_wmask", io_sram_wmask, pend[0].wmask);
      check("sram_way", io_sram_way_en, pend[0].way_en);
    end
    hit_e = 1'b0;
    fd_e  = '0;
    fm_e  = '0;
    foreach (pend[i]) begin
      if (pend[i].addr == io_rd_addr && pend[i].way_en == io_rd_way_en) begin
        hit_e = 1'b1;
        fd_e  = pend[i].data;
        fm_e  = pend[i].wmask;
      end
    end
    check("fwd_hit", io_fwd_hit, hit_e);
    check("fwd_data", io_fwd_data, fd_e);
    check("fwd_wmask", io_fwd_wmask, fm_e);

    @(posedge clock);
    if (reset) begin
      pend.delete();
      starve_m = 0;
      force_m  = 1'b0;
      ack_v_m  = 1'b0;
      ack_s_m  = 1'b0;
    end else begin
      was_busy = (pend.size() > 0);
      push_e   = io_req_valid && (pend.size() != DEPTH);
      ack_v_m  = wen_e;
      if (wen_e) begin
        ack_s_m = pend[0].src;
        void'(pend.pop_front());
      end
      if (push_e) begin
        e = '{way_en: io_req_way_en, addr: io_req_addr, wmask: io_req_wmask,
              data: io_req_data, src: io_req_chosen};
        pend.push_back(e);
      end
      if (force_m) begin
        force_m  = 1'b0;
        starve_m = 0;
      end else if (wen_e) begin
        starve_m = 0;
      end else if (was_busy && io_rd_valid) begin
        if (starve_m < STARVE_LIMIT) starve_m++;
        if (starve_m == STARVE_LIMIT) force_m = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_req(1'b0, '0, '0, 1'b0);
    set_rd(1'b0, '0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state.
    cycle();

    // Single request, read idle: written next cycle, acked the cycle after.
    set_req(1'b1, 12'h010, 64'hA5, 1'b1);
    cycle();
    set_req(1'b0, '0, '0, 1'b0);
    #1 check("single_wen_dir", io_sram_wen, 1'b1);
    check("single_addr_dir", io_sram_addr, 12'h010);
    cycle();
    #1 check("single_ack_dir", io_ack_valid, 1'b1);
    check("single_src_dir", io_ack_source, 1'b1);
    repeat (2) cycle();

    // Three back-to-back requests with the read idle.
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, ADDR_W'(12'h030 + i), DATA_W'($urandom), i[0]);
      cycle();
    end
    set_req(1'b0, '0, '0, 1'b0);
    repeat (4) cycle();

    // Read holds the array with one entry queued: four blocked cycles, then a forced write.
    set_rd(1'b1, 12'h3FF);
    set_req(1'b1, 12'h040, 64'h1234, 1'b0);
    cycle();
    set_req(1'b0, '0, '0, 1'b0);
    repeat (4) cycle();
    #1 check("force_stall_dir", io_rd_stall, 1'b1);
    check("force_wen_dir", io_sram_wen, 1'b1);
    repeat (3) cycle();
    set_rd(1'b0, '0);
    cycle();

    // Forwarding: two entries to the same row, youngest wins; a different row misses.
    set_rd(1'b1, 12'h3FF);
    set_req(1'b1, 12'h020, 64'h1, 1'b0);
    cycle();
    set_req(1'b1, 12'h020, 64'h2, 1'b1);
    cycle();
    set_req(1'b0, '0, '0, 1'b0);
    set_rd(1'b1, 12'h020);
    #1 check("fwd_young_dir", io_fwd_data, 64'h2);
    cycle();
    set_rd(1'b1, 12'h021);
    #1 check("fwd_miss_dir", io_fwd_hit, 1'b0);
    cycle();
    set_rd(1'b0, '0);
    repeat (3) cycle();

    // Full queue drained while a request waits: not accepted that cycle, accepted the next.
    set_rd(1'b1, 12'h3FF);
    set_req(1'b1, 12'h050, 64'h50, 1'b0);
    cycle();
    set_req(1'b1, 12'h051, 64'h51, 1'b1);
    cycle();
    set_rd(1'b0, '0);
    set_req(1'b1, 12'h052, 64'h52, 1'b0);
    #1 check("full_ready_dir", io_req_ready, 1'b0);
    cycle();
    #1 check("after_drain_ready_dir", io_req_ready, 1'b1);
    cycle();
    set_req(1'b0, '0, '0, 1'b0);
    repeat (4) cycle();

    // Reset with two entries pending: both discarded, no acks.
    set_rd(1'b1, 12'h3FF);
    set_req(1'b1, 12'h060, 64'h60, 1'b1);
    cycle();
    set_req(1'b1, 12'h061, 64'h61, 1'b1);
    cycle();
    set_req(1'b0, '0, '0, 1'b0);
    set_rd(1'b0, '0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1 check("reset_empty_dir", io_empty, 1'b1);
    check("reset_wen_dir", io_sram_wen, 1'b0);
    repeat (3) cycle();

    // Randomized traffic over a small address set so forwarding and starvation both occur.
    for (int i = 0; i < 600; i++) begin
      io_req_valid  = 1'($urandom_range(0, 1));
      io_req_addr   = ADDR_W'($urandom_range(0, 3));
      io_req_way_en = NWAYS'($urandom_range(0, 1));
      io_req_wmask  = WMASK_W'($urandom_range(0, 1));
      io_req_data   = {$urandom, $urandom};
      io_req_chosen = 1'($urandom_range(0, 1));
      io_rd_valid   = (i < 300) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 2) == 0);
      io_rd_addr    = ADDR_W'($urandom_range(0, 3));
      io_rd_way_en  = NWAYS'($urandom_range(0, 1));
      reset         = ($urandom_range(0, 149) == 0);
      cycle();
    end
    reset = 1'b0;
    set_req(1'b0, '0, '0, 1'b0);
    set_rd(1'b0, '0);
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
